// File: rtl/udp_ip_hdr_tx.sv
`default_nettype none
// ============================================================================
// Module  : udp_ip_hdr_tx
// Purpose : Serialises an IPv4 + UDP (or UDP-only) header as N-bit beats.
// Revision: 1.0
// ============================================================================
module udp_ip_hdr_tx #(
  parameter int         N        = 4,
  parameter bit         IP_EN    = 1'b1,
  parameter bit         CKSUM_EN = 1'b1,
  parameter logic [7:0] TTL      = 8'd64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          axiiv,
  input  logic [15:0]   src_port_in,
  input  logic [15:0]   dst_port_in,
  input  logic [15:0]   data_length_in,
  input  logic [15:0]   data_checksum_in,
  input  logic [31:0]   src_ip_in,
  input  logic [31:0]   dst_ip_in,
  input  logic          axi_ready,
  output logic          axiov,
  output logic [N-1:0]  axiod,
  output logic          axi_last,
  output logic          busy
);

  localparam int         HDR_W    = 224;
  localparam logic [7:0] IP_LAST  = 8'(160 / N - 1);
  localparam logic [7:0] UDP_LAST = 8'(64 / N - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IP_HDR  = 2'd1;
  localparam logic [1:0] S_UDP_HDR = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [HDR_W-1:0] sh_q, sh_d;
  logic [15:0]      id_q, id_d;

  logic [15:0]      w_ip_len, w_udp_len, w_ip_ck, w_udp_fold, w_udp_ck;
  logic [19:0]      w_ip_sum, w_udp_sum;
  logic [159:0]     w_ip_hdr;
  logic [63:0]      w_udp_hdr;
  logic [HDR_W-1:0] w_load;

  function automatic logic [19:0] zx(input logic [15:0] x);
    return {4'd0, x};
  endfunction

  // Two folds suffice: ten 16-bit words never exceed 20 bits.
  function automatic logic [15:0] oc_fold(input logic [19:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  always_comb begin
    w_ip_len   = data_length_in + 16'd28;
    w_udp_len  = data_length_in + 16'd8;
    w_ip_sum   = zx(16'h4500) + zx(w_ip_len) + zx(id_q) + zx(16'h4000)
               + zx({TTL, 8'h11})
               + zx(src_ip_in[31:16]) + zx(src_ip_in[15:0])
               + zx(dst_ip_in[31:16]) + zx(dst_ip_in[15:0]);
    w_ip_ck    = ~oc_fold(w_ip_sum);
    w_udp_sum  = zx(src_ip_in[31:16]) + zx(src_ip_in[15:0])
               + zx(dst_ip_in[31:16]) + zx(dst_ip_in[15:0])
               + zx(16'h0011) + zx(w_udp_len) + zx(w_udp_len)
               + zx(src_port_in) + zx(dst_port_in) + zx(data_checksum_in);
    w_udp_fold = ~oc_fold(w_udp_sum);
    // A computed zero is sent as all-ones; zero on the wire means "no checksum".
    if (!CKSUM_EN)
      w_udp_ck = 16'h0000;
    else if (w_udp_fold == 16'h0000)
      w_udp_ck = 16'hFFFF;
    else
      w_udp_ck = w_udp_fold;
    w_ip_hdr   = {16'h4500, w_ip_len, id_q, 16'h4000, TTL, 8'h11, w_ip_ck,
                  src_ip_in, dst_ip_in};
    w_udp_hdr  = {src_port_in, dst_port_in, w_udp_len, w_udp_ck};
    w_load     = IP_EN ? {w_ip_hdr, w_udp_hdr} : {w_udp_hdr, 160'd0};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (axiiv) begin
          state_d = IP_EN ? S_IP_HDR : S_UDP_HDR;
          cnt_d   = 8'd0;
          sh_d    = w_load;
        end
      end
      S_IP_HDR: begin
        if (axi_ready) begin
          sh_d = sh_q << N;
          if (cnt_q == IP_LAST) begin
            state_d = S_UDP_HDR;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      S_UDP_HDR: begin
        if (axi_ready) begin
          sh_d = sh_q << N;
          if (cnt_q == UDP_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            if (IP_EN) id_d = id_q + 16'd1;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      sh_q    <= '0;
      id_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      id_q    <= id_d;
    end
  end

  // The shift register drains to zero, so axiod reads 0 whenever idle.
  assign axiov    = (state_q != S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign axi_last = (state_q == S_UDP_HDR) && (cnt_q == UDP_LAST);
  assign axiod    = sh_q[HDR_W-1 -: N];

endmodule
`default_nettype wire

// File: tb/tb_udp_ip_hdr_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_udp_ip_hdr_tx
// Purpose : Self-checking bench for three udp_ip_hdr_tx configurations.
// Revision: 1.0
// ============================================================================
module tb_udp_ip_hdr_tx;

  logic        clk;
  logic        rst, axiiv, axi_ready;
  logic [15:0] src_port_in, dst_port_in, data_length_in, data_checksum_in;
  logic [31:0] src_ip_in, dst_ip_in;

  logic [2:0]  ov_k, al_k, bz_k;
  logic [7:0]  od_a;
  logic [3:0]  od_b;
  logic [1:0]  od_c;
  logic [7:0]  od_k [3];

  localparam int NK  [3] = '{8, 4, 2};
  localparam int IPK [3] = '{1, 0, 1};
  localparam int CKK [3] = '{1, 1, 0};

  int tests = 0, fails = 0;
  bit mon_en = 1'b0, was_rst = 1'b0;

  // model state: pending beats per instance
  logic [7:0]  exp_mem [3][128];
  int          pend [3], pos [3];
  logic [15:0] id_m [3];
  logic [7:0]  log_mem [3][1024];
  int          log_n [3];
  int          lb [3];

  logic [7:0] L34 [28] = '{8'h45, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h40, 8'h00,
                           8'h40, 8'h11, 8'hEA, 8'hDB, 8'h69, 8'h69, 8'h69, 8'h69,
                           8'h12, 8'h12, 8'h6B, 8'h0D, 8'h00, 8'h35, 8'h02, 8'h2A,
                           8'h00, 8'h0C, 8'h0D, 8'hBA};
  logic [3:0] L33 [16] = '{4'h0, 4'h0, 4'h3, 4'h5, 4'h0, 4'h2, 4'h2, 4'hA,
                           4'h0, 4'h0, 4'h0, 4'hC, 4'h0, 4'hD, 4'hB, 4'hA};

  udp_ip_hdr_tx #(.N(8), .IP_EN(1'b1), .CKSUM_EN(1'b1), .TTL(8'd64)) u_a (
    .clk(clk), .rst(rst), .axiiv(axiiv),
    .src_port_in(src_port_in), .dst_port_in(dst_port_in),
    .data_length_in(data_length_in), .data_checksum_in(data_checksum_in),
    .src_ip_in(src_ip_in), .dst_ip_in(dst_ip_in), .axi_ready(axi_ready),
    .axiov(ov_k[0]), .axiod(od_a), .axi_last(al_k[0]), .busy(bz_k[0]));

  udp_ip_hdr_tx #(.N(4), .IP_EN(1'b0), .CKSUM_EN(1'b1), .TTL(8'd64)) u_b (
    .clk(clk), .rst(rst), .axiiv(axiiv),
    .src_port_in(src_port_in), .dst_port_in(dst_port_in),
    .data_length_in(data_length_in), .data_checksum_in(data_checksum_in),
    .src_ip_in(src_ip_in), .dst_ip_in(dst_ip_in), .axi_ready(axi_ready),
    .axiov(ov_k[1]), .axiod(od_b), .axi_last(al_k[1]), .busy(bz_k[1]));

  udp_ip_hdr_tx #(.N(2), .IP_EN(1'b1), .CKSUM_EN(1'b0), .TTL(8'd64)) u_c (
    .clk(clk), .rst(rst), .axiiv(axiiv),
    .src_port_in(src_port_in), .dst_port_in(dst_port_in),
    .data_length_in(data_length_in), .data_checksum_in(data_checksum_in),
    .src_ip_in(src_ip_in), .dst_ip_in(dst_ip_in), .axi_ready(axi_ready),
    .axiov(ov_k[2]), .axiod(od_c), .axi_last(al_k[2]), .busy(bz_k[2]));

  assign od_k[0] = od_a;
  assign od_k[1] = {4'd0, od_b};
  assign od_k[2] = {6'd0, od_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] oca(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  // Expand the header for instance k into its expected beat list.
  function automatic void build(input int k);
    logic [15:0]  ul, tl, s, ipck, uck;
    logic [223:0] all;
    logic [7:0]   byt, m;
    int           nb, cnt;
    ul = data_length_in + 16'd8;
    tl = data_length_in + 16'd28;
    s = 16'h0;
    s = oca(s, 16'h4500); s = oca(s, tl); s = oca(s, id_m[k]); s = oca(s, 16'h4000);
    s = oca(s, 16'h4011);
    s = oca(s, src_ip_in[31:16]); s = oca(s, src_ip_in[15:0]);
    s = oca(s, dst_ip_in[31:16]); s = oca(s, dst_ip_in[15:0]);
    ipck = ~s;
    s = 16'h0;
    s = oca(s, src_ip_in[31:16]); s = oca(s, src_ip_in[15:0]);
    s = oca(s, dst_ip_in[31:16]); s = oca(s, dst_ip_in[15:0]);
    s = oca(s, 16'h0011); s = oca(s, ul); s = oca(s, ul);
    s = oca(s, src_port_in); s = oca(s, dst_port_in); s = oca(s, data_checksum_in);
    uck = ~s;
    if (uck == 16'h0) uck = 16'hFFFF;
    if (CKK[k] == 0) uck = 16'h0;
    if (IPK[k] != 0) begin
      all = {16'h4500, tl, id_m[k], 16'h4000, 8'd64, 8'h11, ipck, src_ip_in, dst_ip_in,
             src_port_in, dst_port_in, ul, uck};
      nb = 28;
    end else begin
      all = {src_port_in, dst_port_in, ul, uck, 160'd0};
      nb = 8;
    end
    m = 8'((1 << NK[k]) - 1);
    cnt = 0;
    for (int i = 0; i < nb; i++) begin
      byt = all[223 - 8*i -: 8];
      for (int j = 0; j < 8 / NK[k]; j++) begin
        exp_mem[k][cnt] = (byt >> (8 - NK[k]*(j+1))) & m;
        cnt++;
      end
    end
    pend[k] = cnt;
    pos[k]  = 0;
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0; pos[k] = 0; id_m[k] = 16'h0; log_n[k] = 0;
    end
  end

  // Compare on the falling edge, then advance the model for the next rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mon_en) begin
        chk("axiov", k, 32'(ov_k[k]), 32'(pend[k] > 0));
        chk("busy", k, 32'(bz_k[k]), 32'(pend[k] > 0));
        chk("axi_last", k, 32'(al_k[k]), 32'(pend[k] == 1));
        if (pend[k] > 0)
          chk("axiod", k, 32'(od_k[k]), 32'(exp_mem[k][pos[k]]));
        else if (was_rst)
          chk("axiod_rst", k, 32'(od_k[k]), 32'd0);
      end
      if (rst) begin
        pend[k] = 0; pos[k] = 0; id_m[k] = 16'h0;
      end else if (pend[k] > 0) begin
        if (axi_ready) begin
          if (log_n[k] < 1024) begin
            log_mem[k][log_n[k]] = od_k[k];
            log_n[k]++;
          end
          pos[k]++;
          pend[k]--;
          if (pend[k] == 0 && IPK[k] != 0) id_m[k] = id_m[k] + 16'd1;
        end
      end else if (axiiv) begin
        build(k);
      end
    end
    was_rst = rst;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while ((pend[0] + pend[1] + pend[2]) != 0 && i < 600) begin
      cyc();
      i++;
    end
    chk("idle_timeout", 0, 32'((pend[0] + pend[1] + pend[2]) != 0), 32'd0);
    cyc();
    chk("idle_axiov", 0, 32'(ov_k), 32'd0);
  endtask

  task automatic set_req();
    src_ip_in = 32'h69696969; dst_ip_in = 32'h12126B0D;
    data_length_in = 16'd4; src_port_in = 16'd53; dst_port_in = 16'd554;
    data_checksum_in = 16'h9FCB;
  endtask

  task automatic mark();
    for (int k = 0; k < 3; k++) lb[k] = log_n[k];
  endtask

  function automatic logic [15:0] c_word(input int base);
    logic [15:0] v;
    v = 16'h0;
    for (int i = 0; i < 8; i++) v = (v << 2) | 16'(log_mem[2][base + i] & 8'h3);
    return v;
  endfunction

  initial begin
    logic [7:0] v0;
    rst = 1'b1; axiiv = 1'b0; axi_ready = 1'b1;
    set_req();
    cyc(); cyc();
    mon_en = 1'b1;
    chk("rst_axiov", 0, 32'(ov_k), 32'd0);
    chk("rst_busy", 0, 32'(bz_k), 32'd0);
    chk("rst_last", 0, 32'(al_k), 32'd0);
    chk("rst_axiod", 0, {od_a, od_b, od_c, 10'd0}, 32'd0);
    rst = 1'b0;
    cyc();

    // Known-answer packets, back-to-back on instance a
    mark();
    axiiv = 1'b1;
    repeat (31) cyc();
    axiiv = 1'b0;
    wait_idle();
    for (int i = 0; i < 28; i++) chk($sformatf("kat_ip_b%0d", i), 0, 32'(log_mem[0][lb[0]+i]), 32'(L34[i]));
    chk("second_id_hi", 0, 32'(log_mem[0][lb[0]+32]), 32'h00);
    chk("second_id_lo", 0, 32'(log_mem[0][lb[0]+33]), 32'h01);
    chk("second_ck_hi", 0, 32'(log_mem[0][lb[0]+38]), 32'hEA);
    chk("second_ck_lo", 0, 32'(log_mem[0][lb[0]+39]), 32'hDA);
    for (int i = 0; i < 16; i++) chk($sformatf("kat_udp_n%0d", i), 1, 32'(log_mem[1][lb[1]+i]), 32'(L33[i]));
    chk("nocksum_udp", 2, 32'(c_word(lb[2] + 104)), 32'h0000);
    chk("nocksum_ip", 2, 32'(c_word(lb[2] + 40)), 32'hEADB);

    // UDP sum folding to 0xFFFF
    src_ip_in = 32'h0; dst_ip_in = 32'h0; data_length_in = 16'd0;
    src_port_in = 16'd0; dst_port_in = 16'd0; data_checksum_in = 16'hFFDE;
    mark();
    axiiv = 1'b1; cyc(); axiiv = 1'b0;
    wait_idle();
    chk("ffff_hi", 0, 32'(log_mem[0][lb[0]+26]), 32'hFF);
    chk("ffff_lo", 0, 32'(log_mem[0][lb[0]+27]), 32'hFF);
    for (int i = 12; i < 16; i++) chk($sformatf("ffff_n%0d", i), 1, 32'(log_mem[1][lb[1]+i]), 32'hF);
    chk("ffff_nocksum", 2, 32'(c_word(lb[2] + 104)), 32'h0000);

    // Abort by reset after five beats
    set_req();
    axiiv = 1'b1; cyc(); axiiv = 1'b0;
    repeat (5) cyc();
    rst = 1'b1; cyc();
    chk("abort_axiov", 0, 32'(ov_k), 32'd0);
    chk("abort_last", 0, 32'(al_k), 32'd0);
    rst = 1'b0;

    // Fresh packet with a 3-cycle stall and an ignored axiiv pulse
    mark();
    axiiv = 1'b1; cyc(); axiiv = 1'b0;
    repeat (4) cyc();
    v0 = od_k[0];
    axi_ready = 1'b0; axiiv = 1'b1;
    repeat (3) begin
      cyc();
      chk("stall_hold", 0, 32'(od_k[0]), 32'(v0));
      chk("stall_valid", 0, 32'(ov_k[0]), 32'd1);
    end
    axi_ready = 1'b1; axiiv = 1'b0;
    wait_idle();
    for (int i = 0; i < 28; i++) chk($sformatf("post_rst_b%0d", i), 0, 32'(log_mem[0][lb[0]+i]), 32'(L34[i]));

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst              = ($urandom_range(0, 199) == 0);
      axiiv            = ($urandom_range(0, 2) == 0);
      axi_ready        = ($urandom_range(0, 3) != 0);
      src_port_in      = 16'($urandom);
      dst_port_in      = 16'($urandom);
      data_length_in   = 16'($urandom);
      data_checksum_in = 16'($urandom);
      src_ip_in        = $urandom;
      dst_ip_in        = $urandom;
      cyc();
    end
    rst = 1'b0; axiiv = 1'b0; axi_ready = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
